step_profile_gen: RTL

Executes a trapezoidal step profile. Consumes the same five-word parameter set that the profile timing calculator uses (N, nn, t0, tna, delta) and emits one step pulse per motor step. Step periods decrease by delta during acceleration, hold at tna during cruise, and mirror back during deceleration. Sits between the motion-parameter registers and the stepper driver pin, downstream of the timing calculator. Total emitted time equals that block's tt, except where the MIN_PERIOD clamp applies.

---
 rtl/step_profile_pkg.sv | 47 ++++
 rtl/step_profile_gen_step_pulse_timer.sv | 47 ++++
 rtl/step_profile_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/step_profile_pkg.sv
// Shared types and constants for the trapezoidal step profile generator.
package step_profile_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ACC_W      = 66;
    localparam int unsigned NUM_PARAMS = 5;

    localparam int unsigned P_N     = 0;
    localparam int unsigned P_NN    = 1;
    localparam int unsigned P_T0    = 2;
    localparam int unsigned P_TNA   = 3;
    localparam int unsigned P_DELTA = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_ACCEL  = 2'd1,
        PH_CRUISE = 2'd2,
        PH_DECEL  = 2'd3
    } phase_t;

    // Move plan captured when the parameter set is latched
    typedef struct packed {
        logic              long_move;
        logic [DATA_W-1:0] accel_n;
        logic [DATA_W-1:0] cruise_n;
        logic [DATA_W-1:0] tna;
        logic [DATA_W-1:0] delta;
    } plan_t;

    function automatic phase_t phase_of(input state_t s);
        case (s)
            ST_ACCEL:  return PH_ACCEL;
            ST_CRUISE: return PH_CRUISE;
            ST_DECEL:  return PH_DECEL;
            default:   return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/step_profile_gen_step_pulse_timer.sv
// Times one step period: step high for PULSE_W cycles, flags the period's final cycle.
module step_pulse_timer
    import step_profile_pkg::*;
#(
    parameter int unsigned PULSE_W = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] period,
    output logic              step,
    output logic              last_cycle
);

    logic [DATA_W-1:0] per_q;
    logic [DATA_W-1:0] idx_q;
    logic              run_q;

    assign last_cycle = run_q && (idx_q == DATA_W'(per_q - DATA_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
            step  <= 1'b0;
        end else if (clear) begin
            idx_q <= '0;
            run_q <= 1'b0;
            step  <= 1'b0;
        end else if (load) begin
            per_q <= period;
            idx_q <= '0;
            run_q <= 1'b1;
            step  <= 1'b1;
        end else if (last_cycle) begin
            run_q <= 1'b0;
            step  <= 1'b0;
        end else if (run_q) begin
            idx_q <= DATA_W'(idx_q + DATA_W'(1));
            step  <= DATA_W'(idx_q + DATA_W'(1)) < DATA_W'(PULSE_W);
        end
    end

endmodule

// File: rtl/step_profile_gen.sv
// Trapezoidal step profile executor: accel / cruise / decel step pulses from a latched parameter set.
// Define STEP_PROFILE_ELAPSED_EN to add the 64-bit busy-cycle counter output 'elapsed'.
module step_profile_gen
    import step_profile_pkg::*;
#(
    parameter int unsigned PULSE_W    = 2,
    parameter int unsigned MIN_PERIOD = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] params [0:NUM_PARAMS-1],
    output logic              step,
    output logic              busy,
    output logic [1:0]        phase,
    output logic [DATA_W-1:0] step_count,
    output logic              finish
`ifdef STEP_PROFILE_ELAPSED_EN
  , output logic [63:0]       elapsed
`endif
);

    localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(MIN_PERIOD);

    function automatic logic signed [ACC_W-1:0] sx(input logic [DATA_W-1:0] u);
        return $signed(ACC_W'(u));
    endfunction

    function automatic logic [DATA_W-1:0] clamp_per(input logic signed [ACC_W-1:0] v);
        if (v < MIN_S) return DATA_W'(MIN_PERIOD);
        return v[DATA_W-1:0];
    endfunction

    state_t                   st_q, st_d;
    plan_t                    plan_q, plan_d, lat_c;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_dn_c, acc_up_c;
    logic [DATA_W-1:0]        cper_q, cper_d;
    logic [DATA_W-1:0]        k_q, k_d;
    logic [DATA_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]        per_c;
    logic [DATA_W:0]          two_nn_c;
    logic                     load_c, clr_c;
    logic                     busy_q, finish_q;
    logic                     step_t, tlast_c;

    // acc holds the unclamped period last issued in accel/decel
    assign acc_dn_c = acc_q - sx(plan_q.delta);
    assign acc_up_c = acc_q + sx(plan_q.delta);
    assign two_nn_c = {params[P_NN], 1'b0};

    always_comb begin
        lat_c.long_move = {1'b0, params[P_N]} > two_nn_c;
        lat_c.accel_n   = lat_c.long_move ? params[P_NN] : (params[P_N] >> 1);
        lat_c.cruise_n  = lat_c.long_move ? DATA_W'(params[P_N] - two_nn_c[DATA_W-1:0])
                                          : DATA_W'(params[P_N][0]);
        lat_c.tna       = params[P_TNA];
        lat_c.delta     = params[P_DELTA];
    end

    always_comb begin
        st_d   = st_q;
        plan_d = plan_q;
        acc_d  = acc_q;
        cper_d = cper_q;
        k_d    = k_q;
        cnt_d  = cnt_q;
        per_c  = '0;
        load_c = 1'b0;
        clr_c  = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    plan_d = lat_c;
                    cnt_d  = '0;
                    k_d    = DATA_W'(1);
                    if (params[P_N] == '0) begin
                        st_d = ST_DONE;
                    end else if (lat_c.accel_n != '0) begin
                        st_d   = ST_ACCEL;
                        load_c = 1'b1;
                        acc_d  = sx(params[P_T0]);
                        per_c  = clamp_per(sx(params[P_T0]));
                    end else begin
                        st_d   = ST_CRUISE;
                        load_c = 1'b1;
                        per_c  = clamp_per(sx(lat_c.long_move ? params[P_TNA] : params[P_T0]));
                        cper_d = per_c;
                    end
                end
            end
            ST_ACCEL: begin
                if (tlast_c) begin
                    load_c = 1'b1;
                    if (k_q < plan_q.accel_n) begin
                        acc_d = acc_dn_c;
                        per_c = clamp_per(acc_dn_c);
                        k_d   = DATA_W'(k_q + DATA_W'(1));
                    end else if (plan_q.cruise_n != '0) begin
                        st_d   = ST_CRUISE;
                        per_c  = plan_q.long_move ? clamp_per(sx(plan_q.tna)) : clamp_per(acc_dn_c);
                        cper_d = per_c;
                        k_d    = DATA_W'(1);
                    end else begin
                        st_d  = ST_DECEL;
                        per_c = clamp_per(acc_q);
                        k_d   = DATA_W'(1);
                    end
                end
            end
            ST_CRUISE: begin
                if (tlast_c) begin
                    if (k_q < plan_q.cruise_n) begin
                        load_c = 1'b1;
                        per_c  = cper_q;
                        k_d    = DATA_W'(k_q + DATA_W'(1));
                    end else if (plan_q.accel_n != '0) begin
                        st_d   = ST_DECEL;
                        load_c = 1'b1;
                        per_c  = clamp_per(acc_q);
                        k_d    = DATA_W'(1);
                    end else begin
                        st_d = ST_DONE;
                    end
                end
            end
            ST_DECEL: begin
                if (tlast_c) begin
                    if (k_q < plan_q.accel_n) begin
                        load_c = 1'b1;
                        acc_d  = acc_up_c;
                        per_c  = clamp_per(acc_up_c);
                        k_d    = DATA_W'(k_q + DATA_W'(1));
                    end else begin
                        st_d = ST_DONE;
                    end
                end
            end
            default: ;
        endcase

        if (load_c) cnt_d = DATA_W'(cnt_d + DATA_W'(1));

        // Dropping start outside IDLE abandons the move
        if (st_q != ST_IDLE && !start) begin
            st_d   = ST_IDLE;
            load_c = 1'b0;
            clr_c  = 1'b1;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q     <= ST_IDLE;
            plan_q   <= '0;
            acc_q    <= '0;
            cper_q   <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            phase    <= PH_IDLE;
        end else begin
            st_q     <= st_d;
            plan_q   <= plan_d;
            acc_q    <= acc_d;
            cper_q   <= cper_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            busy_q   <= (st_d == ST_ACCEL) || (st_d == ST_CRUISE) || (st_d == ST_DECEL);
            finish_q <= (st_d == ST_DONE);
            phase    <= phase_of(st_d);
        end
    end

    step_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .clear      (clr_c),
        .period     (per_c),
        .step       (step_t),
        .last_cycle (tlast_c)
    );

    // Abort must silence the driver pin and status in the same cycle start drops
    assign step       = step_t & start;
    assign busy       = busy_q & start;
    assign step_count = start ? cnt_q : '0;
    assign finish     = finish_q;

`ifdef STEP_PROFILE_ELAPSED_EN
    logic [63:0] el_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            el_q <= '0;
        end else if (st_q == ST_IDLE || st_d == ST_IDLE) begin
            el_q <= '0;
        end else if (busy_q) begin
            el_q <= el_q + 64'd1;
        end
    end

    assign elapsed = el_q;
`endif

endmodule
